// File: rtl/udp_tx_arbiter_if.sv
// Byte-wide AXI-Stream bundle between NUM_SRC sources, the arbiter and the UDP TX payload port.
// Signal prefixes (i_/o_) are seen from the arbiter side.
interface udp_tx_arbiter_if #(
  parameter int NUM_SRC = 2
);
  logic [8*NUM_SRC-1:0] i_s_axis_tdata;
  logic [NUM_SRC-1:0]   i_s_axis_tvalid;
  logic [NUM_SRC-1:0]   i_s_axis_tlast;
  logic [NUM_SRC-1:0]   o_s_axis_tready;
  logic [7:0]           o_m_axis_tdata;
  logic                 o_m_axis_tvalid;
  logic                 o_m_axis_tlast;
  logic                 i_m_axis_tready;

  modport slave (
    input  i_s_axis_tdata, i_s_axis_tvalid, i_s_axis_tlast, i_m_axis_tready,
    output o_s_axis_tready, o_m_axis_tdata, o_m_axis_tvalid, o_m_axis_tlast
  );

  modport master (
    output i_s_axis_tdata, i_s_axis_tvalid, i_s_axis_tlast, i_m_axis_tready,
    input  o_s_axis_tready, o_m_axis_tdata, o_m_axis_tvalid, o_m_axis_tlast
  );
endinterface

// File: rtl/udp_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one 8-bit UDP TX payload stream between
// NUM_SRC sources; frames longer than MAX_LEN are cut with a forced tlast and the tail drained.
module udp_tx_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int MAX_LEN = 1472
) (
  input  logic               i_clk,
  input  logic               i_rst,
  udp_tx_arbiter_if.slave    axis,
  output logic [NUM_SRC-1:0] o_grant,
  output logic               o_busy,
  output logic               o_trunc,
  output logic [15:0]        o_frame_cnt
);

  localparam int CW = $clog2(MAX_LEN + 1);
  localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [CW-1:0] LAST_IDX  = CW'(MAX_LEN - 1);
  localparam logic [IW-1:0] FIRST_PTR = IW'(NUM_SRC - 1);
  localparam logic [IW:0]   SRC_W     = (IW + 1)'(NUM_SRC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_XFER  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [NUM_SRC-1:0] grant_q, grant_d;
  logic [IW-1:0]      last_ptr_q, last_ptr_d;
  logic [CW-1:0]      byte_cnt_q, byte_cnt_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d;
  logic               trunc_q, trunc_d;

  logic               in_xfer;
  logic               in_drain;
  logic               sel_valid;
  logic               sel_last;
  logic [7:0]         sel_data;
  logic [7:0]         sel_masked [NUM_SRC];
  logic               at_max;
  logic               hs;

  logic               win_found;
  logic [IW-1:0]      win_idx;
  logic [IW:0]        scan_idx;

  assign in_xfer  = (state_q == ST_XFER);
  assign in_drain = (state_q == ST_DRAIN);

  // The one-hot grant doubles as the data-mux select; zero grant yields zero data.
  generate
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
      assign sel_masked[gi] = axis.i_s_axis_tdata[8*gi +: 8] & {8{grant_q[gi]}};
      assign axis.o_s_axis_tready[gi] =
        grant_q[gi] & ((in_xfer & axis.i_m_axis_tready) | in_drain);
    end
  endgenerate

  always_comb begin
    sel_data = 8'h00;
    for (int k = 0; k < NUM_SRC; k++) begin
      sel_data = sel_data | sel_masked[k];
    end
  end

  assign sel_valid = |(axis.i_s_axis_tvalid & grant_q);
  assign sel_last  = |(axis.i_s_axis_tlast & grant_q);
  assign at_max    = (byte_cnt_q == LAST_IDX);

  assign axis.o_m_axis_tvalid = in_xfer & sel_valid;
  assign axis.o_m_axis_tdata  = in_xfer ? sel_data : 8'h00;
  assign axis.o_m_axis_tlast  = in_xfer & sel_valid & (sel_last | at_max);
  assign hs = axis.o_m_axis_tvalid & axis.i_m_axis_tready;

  // Round-robin scan starting just after the previous winner, wrapping modulo NUM_SRC.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_ptr_q;
    scan_idx  = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      scan_idx = {1'b0, last_ptr_q} + (IW + 1)'(k);
      if (scan_idx >= SRC_W) begin
        scan_idx = scan_idx - SRC_W;
      end
      if (!win_found && axis.i_s_axis_tvalid[scan_idx[IW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = scan_idx[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_ptr_d  = last_ptr_q;
    byte_cnt_d  = byte_cnt_q;
    frame_cnt_d = frame_cnt_q;
    trunc_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        byte_cnt_d = '0;
        grant_d    = '0;
        if (win_found) begin
          grant_d    = NUM_SRC'(1) << win_idx;
          last_ptr_d = win_idx;
          state_d    = ST_XFER;
        end
      end
      ST_XFER: begin
        if (hs) begin
          byte_cnt_d = byte_cnt_q + CW'(1);
          // A genuine tlast on the MAX_LEN-th byte wins over truncation.
          if (sel_last) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            grant_d     = '0;
            state_d     = ST_IDLE;
          end else if (at_max) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
            trunc_d     = 1'b1;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (sel_valid && sel_last) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_ptr_q  <= FIRST_PTR;
      byte_cnt_q  <= '0;
      frame_cnt_q <= 16'd0;
      trunc_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_ptr_q  <= last_ptr_d;
      byte_cnt_q  <= byte_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      trunc_q     <= trunc_d;
    end
  end

  assign o_grant     = grant_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_trunc     = trunc_q;
  assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Directed bench for udp_tx_arbiter (NUM_SRC=2, MAX_LEN=4): queue-fed sources, output monitor,
// one task per scenario with hand-computed expectations.
module tb_udp_tx_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  udp_tx_arbiter_if #(.NUM_SRC(2)) bus ();

  logic [1:0]  grant;
  logic        busy;
  logic        trunc;
  logic [15:0] frame_cnt;

  udp_tx_arbiter #(.NUM_SRC(2), .MAX_LEN(4)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .axis        (bus),
    .o_grant     (grant),
    .o_busy      (busy),
    .o_trunc     (trunc),
    .o_frame_cnt (frame_cnt)
  );

  logic [7:0] s0_data = 8'h00, s1_data = 8'h00;
  logic       s0_valid = 1'b0, s1_valid = 1'b0;
  logic       s0_last = 1'b0, s1_last = 1'b0;
  logic       m_tready = 1'b1;

  assign bus.i_s_axis_tdata  = {s1_data, s0_data};
  assign bus.i_s_axis_tvalid = {s1_valid, s0_valid};
  assign bus.i_s_axis_tlast  = {s1_last, s0_last};
  assign bus.i_m_axis_tready = m_tready;

  logic [1:0] s_tready;
  logic [7:0] m_tdata;
  logic       m_tvalid, m_tlast;
  assign s_tready = bus.o_s_axis_tready;
  assign m_tdata  = bus.o_m_axis_tdata;
  assign m_tvalid = bus.o_m_axis_tvalid;
  assign m_tlast  = bus.o_m_axis_tlast;

  // Each source queue holds {tlast, data}; the head is presented until it handshakes.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic hs0, hs1;

  always begin
    @(negedge clk);
    hs0 = s0_valid & s_tready[0];
    @(posedge clk);
    #1;
    if (hs0 && q0.size() > 0) void'(q0.pop_front());
    if (q0.size() > 0) begin
      s0_valid = 1'b1; s0_data = q0[0][7:0]; s0_last = q0[0][8];
    end else begin
      s0_valid = 1'b0; s0_data = 8'h00; s0_last = 1'b0;
    end
  end

  always begin
    @(negedge clk);
    hs1 = s1_valid & s_tready[1];
    @(posedge clk);
    #1;
    if (hs1 && q1.size() > 0) void'(q1.pop_front());
    if (q1.size() > 0) begin
      s1_valid = 1'b1; s1_data = q1[0][7:0]; s1_last = q1[0][8];
    end else begin
      s1_valid = 1'b0; s1_data = 8'h00; s1_last = 1'b0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] out_q[$];
  int         out_cyc[$];
  logic [1:0] grant_log[$];
  logic [1:0] prev_grant = 2'b00;
  int trunc_cnt = 0;
  int viol_cnt = 0;
  int stall_cnt = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_tvalid && m_tready) begin
        out_q.push_back({m_tlast, m_tdata});
        out_cyc.push_back(cyc);
      end
      if (trunc) trunc_cnt++;
      if ((s_tready & ~grant) != 2'b00) viol_cnt++;
      if (busy && !m_tvalid) stall_cnt++;
      if (grant != prev_grant && grant != 2'b00) grant_log.push_back(grant);
    end
    prev_grant = grant;
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (grant !== 2'b00) begin $display("FAIL reset_grant got=%b want=00", grant); failures++; end
    checks++; if (busy !== 1'b0) begin $display("FAIL reset_busy got=%b want=0", busy); failures++; end
    checks++; if (trunc !== 1'b0) begin $display("FAIL reset_trunc got=%b want=0", trunc); failures++; end
    checks++; if (frame_cnt !== 16'd0) begin $display("FAIL reset_frame_cnt got=%0d want=0", frame_cnt); failures++; end
    checks++; if ({m_tvalid, m_tlast, m_tdata} !== 10'd0) begin $display("FAIL reset_m_axis got=%b/%b/%h want=0/0/00", m_tvalid, m_tlast, m_tdata); failures++; end
    checks++; if (s_tready !== 2'b00) begin $display("FAIL reset_s_tready got=%b want=00", s_tready); failures++; end
    rst = 1'b0;
  endtask

  task automatic test_single();
    logic [8:0] exp [3];
    exp = '{{1'b0, 8'h3A}, {1'b0, 8'h32}, {1'b1, 8'h52}};
    out_q.delete(); out_cyc.delete();
    @(negedge clk); #1;
    for (int i = 0; i < 3; i++) q0.push_back(exp[i]);
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00 || m_tvalid !== 1'b0) begin $display("FAIL single_latency got grant=%b tvalid=%b want 00/0", grant, m_tvalid); failures++; end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01) begin $display("FAIL single_grant got=%b want=01", grant); failures++; end
    checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h3A || s_tready !== 2'b01 || busy !== 1'b1) begin
      $display("FAIL single_first_beat got v=%b d=%h rdy=%b busy=%b want 1/3a/01/1", m_tvalid, m_tdata, s_tready, busy); failures++; end
    for (int i = 0; i < 20 && out_q.size() < 3; i++) begin @(negedge clk); #1; end
    @(negedge clk); #1;
    checks++; if (out_q.size() != 3) begin $display("FAIL single_count got=%0d want=3", out_q.size()); failures++; end
    for (int i = 0; i < 3 && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== exp[i]) begin $display("FAIL single_byte%0d got=%h want=%h", i, out_q[i], exp[i]); failures++; end
    end
    if (out_q.size() == 3) begin
      checks++; if (out_cyc[2] - out_cyc[0] != 2) begin $display("FAIL single_span got=%0d want=2", out_cyc[2] - out_cyc[0]); failures++; end
    end
    checks++; if (frame_cnt !== 16'd1 || grant !== 2'b00) begin $display("FAIL single_end got cnt=%0d grant=%b want 1/00", frame_cnt, grant); failures++; end
  endtask

  task automatic test_round_robin();
    logic [7:0] bases [4];
    logic [8:0] exp;
    logic [1:0] exp_g [4];
    int v0, t0;
    bases = '{8'h10, 8'h20, 8'h30, 8'h40};
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
    @(negedge clk); #1; rst = 1'b1;
    @(negedge clk); #1; rst = 1'b0;
    out_q.delete(); out_cyc.delete(); grant_log.delete();
    v0 = viol_cnt; t0 = trunc_cnt;
    for (int i = 0; i < 4; i++) begin
      q0.push_back({i == 3, 8'h10 + 8'(i)});
      q1.push_back({i == 3, 8'h20 + 8'(i)});
    end
    for (int i = 0; i < 4; i++) begin
      q0.push_back({i == 3, 8'h30 + 8'(i)});
      q1.push_back({i == 3, 8'h40 + 8'(i)});
    end
    for (int i = 0; i < 80 && out_q.size() < 16; i++) begin @(negedge clk); #1; end
    @(negedge clk); #1;
    checks++; if (out_q.size() != 16) begin $display("FAIL rr_count got=%0d want=16", out_q.size()); failures++; end
    for (int i = 0; i < 16 && i < out_q.size(); i++) begin
      exp = {i % 4 == 3, bases[i / 4] + 8'(i % 4)};
      checks++; if (out_q[i] !== exp) begin $display("FAIL rr_byte%0d got=%h want=%h", i, out_q[i], exp); failures++; end
    end
    if (out_q.size() == 16) begin
      for (int f = 0; f < 4; f++) begin
        checks++; if (out_cyc[4*f+3] - out_cyc[4*f] != 3) begin $display("FAIL rr_frame%0d_span got=%0d want=3", f, out_cyc[4*f+3] - out_cyc[4*f]); failures++; end
      end
      for (int f = 0; f < 3; f++) begin
        checks++; if (out_cyc[4*f+4] - out_cyc[4*f+3] != 2) begin $display("FAIL rr_gap%0d got=%0d want=2", f, out_cyc[4*f+4] - out_cyc[4*f+3]); failures++; end
      end
    end
    checks++; if (grant_log.size() != 4) begin $display("FAIL rr_grant_count got=%0d want=4", grant_log.size()); failures++; end
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      checks++; if (grant_log[i] !== exp_g[i]) begin $display("FAIL rr_grant%0d got=%b want=%b", i, grant_log[i], exp_g[i]); failures++; end
    end
    checks++; if (viol_cnt != v0) begin $display("FAIL rr_ready_leak got=%0d want=0", viol_cnt - v0); failures++; end
    checks++; if (trunc_cnt != t0) begin $display("FAIL rr_trunc got=%0d want=0", trunc_cnt - t0); failures++; end
    checks++; if (frame_cnt !== 16'd4) begin $display("FAIL rr_frame_cnt got=%0d want=4", frame_cnt); failures++; end
  endtask

  task automatic test_backpressure();
    int pat [7];
    int idx;
    pat = '{1, 0, 1, 0, 1, 0, 1};
    idx = 0;
    out_q.delete();
    m_tready = 1'b0;
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) q1.push_back({i == 3, 8'h51 + 8'(i)});
    for (int i = 0; i < 10 && grant !== 2'b10; i++) begin @(negedge clk); #1; end
    checks++; if (grant !== 2'b10) begin $display("FAIL bp_grant got=%b want=10", grant); failures++; end
    checks++; if (m_tdata !== 8'h51 || s_tready !== 2'b00) begin $display("FAIL bp_stall0 got d=%h rdy=%b want 51/00", m_tdata, s_tready); failures++; end
    for (int c = 0; c < 7; c++) begin
      @(posedge clk); #2;
      m_tready = pat[c][0];
      @(negedge clk); #1;
      checks++; if (m_tvalid !== 1'b1 || m_tdata !== 8'h51 + 8'(idx)) begin
        $display("FAIL bp_data_c%0d got v=%b d=%h want 1/%h", c, m_tvalid, m_tdata, 8'h51 + 8'(idx)); failures++; end
      checks++; if (s_tready !== {m_tready, 1'b0}) begin $display("FAIL bp_ready_c%0d got=%b want=%b", c, s_tready, {m_tready, 1'b0}); failures++; end
      if (pat[c] != 0) idx++;
    end
    m_tready = 1'b1;
    @(negedge clk); #1;
    checks++; if (out_q.size() != 4) begin $display("FAIL bp_count got=%0d want=4", out_q.size()); failures++; end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== {i == 3, 8'h51 + 8'(i)}) begin $display("FAIL bp_byte%0d got=%h want=%h", i, out_q[i], {i == 3, 8'h51 + 8'(i)}); failures++; end
    end
    checks++; if (grant !== 2'b00) begin $display("FAIL bp_end_grant got=%b want=00", grant); failures++; end
  endtask

  task automatic test_truncation();
    int t0, s0;
    logic [15:0] f0;
    out_q.delete();
    t0 = trunc_cnt; s0 = stall_cnt; f0 = frame_cnt;
    @(negedge clk); #1;
    for (int i = 0; i < 7; i++) q0.push_back({i == 6, 8'h61 + 8'(i)});
    for (int i = 0; i < 40 && (q0.size() != 0 || grant !== 2'b00); i++) begin @(negedge clk); #1; end
    @(negedge clk); #1;
    checks++; if (out_q.size() != 4) begin $display("FAIL trunc_count got=%0d want=4", out_q.size()); failures++; end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== {i == 3, 8'h61 + 8'(i)}) begin $display("FAIL trunc_byte%0d got=%h want=%h", i, out_q[i], {i == 3, 8'h61 + 8'(i)}); failures++; end
    end
    checks++; if (trunc_cnt - t0 != 1) begin $display("FAIL trunc_pulses got=%0d want=1", trunc_cnt - t0); failures++; end
    checks++; if (stall_cnt - s0 != 3) begin $display("FAIL trunc_drain_cycles got=%0d want=3", stall_cnt - s0); failures++; end
    checks++; if (q0.size() != 0) begin $display("FAIL trunc_src_left got=%0d want=0", q0.size()); failures++; end
    checks++; if (frame_cnt !== f0 + 16'd1 || busy !== 1'b0) begin $display("FAIL trunc_end got cnt=%0d busy=%b want %0d/0", frame_cnt, busy, f0 + 16'd1); failures++; end
  endtask

  task automatic test_exact_max();
    int t0, s0;
    logic [15:0] f0;
    out_q.delete();
    t0 = trunc_cnt; s0 = stall_cnt; f0 = frame_cnt;
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) q0.push_back({i == 3, 8'h71 + 8'(i)});
    for (int i = 0; i < 30 && (q0.size() != 0 || grant !== 2'b00); i++) begin @(negedge clk); #1; end
    @(negedge clk); #1;
    checks++; if (out_q.size() != 4) begin $display("FAIL exact_count got=%0d want=4", out_q.size()); failures++; end
    for (int i = 0; i < 4 && i < out_q.size(); i++) begin
      checks++; if (out_q[i] !== {i == 3, 8'h71 + 8'(i)}) begin $display("FAIL exact_byte%0d got=%h want=%h", i, out_q[i], {i == 3, 8'h71 + 8'(i)}); failures++; end
    end
    checks++; if (trunc_cnt != t0) begin $display("FAIL exact_trunc got=%0d want=0", trunc_cnt - t0); failures++; end
    checks++; if (stall_cnt != s0) begin $display("FAIL exact_drain_cycles got=%0d want=0", stall_cnt - s0); failures++; end
    checks++; if (frame_cnt !== f0 + 16'd1 || busy !== 1'b0) begin $display("FAIL exact_end got cnt=%0d busy=%b want %0d/0", frame_cnt, busy, f0 + 16'd1); failures++; end
  endtask

  task automatic test_reset_midframe();
    out_q.delete();
    @(negedge clk); #1;
    for (int i = 0; i < 4; i++) q0.push_back({i == 3, 8'h81 + 8'(i)});
    for (int i = 0; i < 20 && out_q.size() < 2; i++) begin @(negedge clk); #1; end
    checks++; if (out_q.size() != 2) begin $display("FAIL midrst_pre_count got=%0d want=2", out_q.size()); failures++; end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++; if (grant !== 2'b00 || busy !== 1'b0 || trunc !== 1'b0) begin $display("FAIL midrst_status got g=%b b=%b t=%b want 00/0/0", grant, busy, trunc); failures++; end
    checks++; if (m_tvalid !== 1'b0 || m_tlast !== 1'b0 || s_tready !== 2'b00) begin $display("FAIL midrst_axis got v=%b l=%b rdy=%b want 0/0/00", m_tvalid, m_tlast, s_tready); failures++; end
    checks++; if (frame_cnt !== 16'd0) begin $display("FAIL midrst_frame_cnt got=%0d want=0", frame_cnt); failures++; end
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    out_q.delete(); grant_log.delete();
    for (int i = 0; i < 2; i++) begin
      q0.push_back({i == 1, 8'h91 + 8'(i)});
      q1.push_back({i == 1, 8'hA1 + 8'(i)});
    end
    for (int i = 0; i < 30 && out_q.size() < 4; i++) begin @(negedge clk); #1; end
    @(negedge clk); #1;
    checks++; if (grant_log.size() < 1 || grant_log[0] !== 2'b01) begin $display("FAIL midrst_priority got n=%0d first=%b want 01", grant_log.size(), grant_log.size() > 0 ? grant_log[0] : 2'b00); failures++; end
    checks++; if (out_q.size() != 4 || out_q[0] !== {1'b0, 8'h91}) begin $display("FAIL midrst_first_byte got n=%0d want 4 starting 091", out_q.size()); failures++; end
    checks++; if (frame_cnt !== 16'd2) begin $display("FAIL midrst_post_cnt got=%0d want=2", frame_cnt); failures++; end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_truncation();
    test_exact_max();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
